// File: rtl/cgra_im_loader_pkg.sv
// Shared types for the CGRA instruction-memory loader.
// Loader state machine encoding and DTL address field positions.
package cgra_im_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD
    } loaderState_t;

    localparam int SEL_WIDTH = 4;
    localparam int WORD_ADDR_LSB = 2;

endpackage

// File: rtl/cgra_imm_beat_packer.sv
// Holds the low beat of an immediate instruction and joins it with the
// high beat; flags a low beat that turns out to be the last of its burst.
module cgra_imm_beat_packer #(
    parameter int INTERFACE_WIDTH = 32,
    parameter int I_IMM_WIDTH = 33
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iStoreLo,
    input  logic                         iLast,
    input  logic [INTERFACE_WIDTH-1:0]   iData,
    input  logic [INTERFACE_WIDTH/8-1:0] iEn,
    output logic [I_IMM_WIDTH-1:0]       oWord,
    output logic                         oAnyEn,
    output logic                         oDangling
);

    logic [INTERFACE_WIDTH-1:0] loData;
    logic                       loEn;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            loData <= '0;
            loEn <= 1'b0;
        end else if (iStoreLo) begin
            loData <= iData;
            loEn <= |iEn;
        end
    end

    assign oWord = {iData[I_IMM_WIDTH-INTERFACE_WIDTH-1:0], loData};
    assign oAnyEn = loEn | (|iEn);
    assign oDangling = iStoreLo & iLast;

endmodule

// File: rtl/cgra_im_loader.sv
// Moves DTL write bursts into the CGRA immediate and decoder instruction
// memories; reads are answered with zero data.
module cgra_im_loader
    import cgra_im_loader_pkg::*;
#(
    parameter int INTERFACE_WIDTH = 32,
    parameter int INTERFACE_ADDR_WIDTH = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int I_WIDTH = 12,
    parameter int I_IMM_WIDTH = 33,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_IMM = 3,
    parameter int NUM_ID = 6,
    parameter int SEL_LSB = 16
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iDTL_CommandValid,
    output logic                             oDTL_CommandAccept,
    input  logic                             iDTL_CommandReadWrite,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize,
    input  logic                             iDTL_WriteValid,
    output logic                             oDTL_WriteAccept,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData,
    input  logic [INTERFACE_WIDTH/8-1:0]     iDTL_WriteEnable,
    input  logic                             iDTL_WriteLast,
    output logic                             oDTL_ReadValid,
    input  logic                             iDTL_ReadAccept,
    output logic                             oDTL_ReadLast,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData,
    output logic [NUM_IMM+NUM_ID-1:0]        oIM_WriteEnable,
    output logic [IM_MEM_ADDR_WIDTH-1:0]     oIM_WriteAddress,
    output logic [I_WIDTH-1:0]               oIM_WriteData,
    output logic [I_IMM_WIDTH-1:0]           oIM_WriteData_IMM,
    output logic                             oBusy,
    output logic                             oLoadDone,
    output logic                             oError
);

    localparam int NUM_MEM = NUM_IMM + NUM_ID;
    localparam int CNT_W = INTERFACE_BLOCK_WIDTH + 1;
    localparam logic [SEL_WIDTH-1:0] SEL_IMM_END = SEL_WIDTH'(NUM_IMM);
    localparam logic [SEL_WIDTH-1:0] SEL_END = SEL_WIDTH'(NUM_MEM);

    loaderState_t                 state;
    logic [SEL_WIDTH-1:0]         sel;
    logic [IM_MEM_ADDR_WIDTH-1:0] wordAddr;
    logic [CNT_W-1:0]             beatCnt;
    logic                         donePending;

    logic                   isImm;
    logic                   selValid;
    logic                   beat;
    logic                   loPhase;
    logic                   lastBeat;
    logic                   storeLo;
    logic                   packAnyEn;
    logic                   anyEn;
    logic                   dangling;
    logic                   doWrite;
    logic [I_IMM_WIDTH-1:0] immWord;
    logic [NUM_MEM-1:0]     selOneHot;
    logic [SEL_WIDTH-1:0]   cmdSel;
    logic                   unusedAddr;

    assign cmdSel = iDTL_Address[SEL_LSB +: SEL_WIDTH];
    assign isImm = sel < SEL_IMM_END;
    assign selValid = sel < SEL_END;
    assign beat = iDTL_WriteValid && oDTL_WriteAccept;
    assign loPhase = isImm && state == WR_LO;
    assign lastBeat = iDTL_WriteLast || beatCnt == CNT_W'(1);
    assign storeLo = beat && loPhase;
    assign anyEn = isImm ? packAnyEn : |iDTL_WriteEnable;
    assign doWrite = beat && !loPhase && selValid && anyEn;
    assign selOneHot = NUM_MEM'(1) << sel;
    assign unusedAddr = ^iDTL_Address;

    assign oBusy = state != IDLE;
    assign oDTL_ReadData = '0;

    cgra_imm_beat_packer #(
        .INTERFACE_WIDTH(INTERFACE_WIDTH),
        .I_IMM_WIDTH(I_IMM_WIDTH)
    ) uPacker (
        .iClk(iClk),
        .iReset(iReset),
        .iStoreLo(storeLo),
        .iLast(lastBeat),
        .iData(iDTL_WriteData),
        .iEn(iDTL_WriteEnable),
        .oWord(immWord),
        .oAnyEn(packAnyEn),
        .oDangling(dangling)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= IDLE;
            sel <= '0;
            wordAddr <= '0;
            beatCnt <= '0;
            donePending <= 1'b0;
            oDTL_CommandAccept <= 1'b0;
            oDTL_WriteAccept <= 1'b0;
            oDTL_ReadValid <= 1'b0;
            oDTL_ReadLast <= 1'b0;
            oIM_WriteEnable <= '0;
            oIM_WriteAddress <= '0;
            oIM_WriteData <= '0;
            oIM_WriteData_IMM <= '0;
            oLoadDone <= 1'b0;
            oError <= 1'b0;
        end else begin
            oIM_WriteEnable <= '0;
            oLoadDone <= donePending;
            donePending <= 1'b0;
            unique case (state)
                IDLE: begin
                    oDTL_CommandAccept <= 1'b1;
                    if (iDTL_CommandValid && oDTL_CommandAccept) begin
                        sel <= cmdSel;
                        wordAddr <= iDTL_Address[WORD_ADDR_LSB +: IM_MEM_ADDR_WIDTH];
                        beatCnt <= CNT_W'(iDTL_BlockSize) + CNT_W'(1);
                        oDTL_CommandAccept <= 1'b0;
                        if (iDTL_CommandReadWrite) begin
                            state <= RD;
                            oDTL_ReadValid <= 1'b1;
                            oDTL_ReadLast <= iDTL_BlockSize == '0;
                        end else begin
                            state <= WR_LO;
                            oDTL_WriteAccept <= 1'b1;
                            if (cmdSel >= SEL_END) oError <= 1'b1;
                        end
                    end
                end
                WR_LO, WR_HI: begin
                    if (beat) begin
                        beatCnt <= beatCnt - CNT_W'(1);
                        if (loPhase) begin
                            state <= WR_HI;
                        end else begin
                            wordAddr <= wordAddr + 1'b1;
                            state <= WR_LO;
                        end
                        if (doWrite) begin
                            oIM_WriteEnable <= selOneHot;
                            oIM_WriteAddress <= wordAddr;
                            oIM_WriteData <= iDTL_WriteData[I_WIDTH-1:0];
                            oIM_WriteData_IMM <= immWord;
                        end
                        if (dangling) oError <= 1'b1;
                        // done pulse trails the final strobe when one is issued
                        if (lastBeat) begin
                            state <= IDLE;
                            oDTL_WriteAccept <= 1'b0;
                            oDTL_CommandAccept <= 1'b1;
                            if (doWrite) donePending <= 1'b1;
                            else oLoadDone <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (oDTL_ReadValid && iDTL_ReadAccept) begin
                        beatCnt <= beatCnt - CNT_W'(1);
                        oDTL_ReadLast <= beatCnt == CNT_W'(2);
                        if (beatCnt == CNT_W'(1)) begin
                            state <= IDLE;
                            oDTL_ReadValid <= 1'b0;
                            oDTL_ReadLast <= 1'b0;
                            oDTL_CommandAccept <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_im_loader.sv
// Self-checking bench for cgra_im_loader: directed bursts against a
// queue-based model of the expected instruction-memory writes.
module tb_cgra_im_loader;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iDTL_CommandValid;
    logic        oDTL_CommandAccept;
    logic        iDTL_CommandReadWrite;
    logic [31:0] iDTL_Address;
    logic [4:0]  iDTL_BlockSize;
    logic        iDTL_WriteValid;
    logic        oDTL_WriteAccept;
    logic [31:0] iDTL_WriteData;
    logic [3:0]  iDTL_WriteEnable;
    logic        iDTL_WriteLast;
    logic        oDTL_ReadValid;
    logic        iDTL_ReadAccept;
    logic        oDTL_ReadLast;
    logic [31:0] oDTL_ReadData;
    logic [8:0]  oIM_WriteEnable;
    logic [7:0]  oIM_WriteAddress;
    logic [11:0] oIM_WriteData;
    logic [32:0] oIM_WriteData_IMM;
    logic        oBusy;
    logic        oLoadDone;
    logic        oError;

    always #5 iClk = ~iClk;

    cgra_im_loader dut (
        .iClk(iClk),
        .iReset(iReset),
        .iDTL_CommandValid(iDTL_CommandValid),
        .oDTL_CommandAccept(oDTL_CommandAccept),
        .iDTL_CommandReadWrite(iDTL_CommandReadWrite),
        .iDTL_Address(iDTL_Address),
        .iDTL_BlockSize(iDTL_BlockSize),
        .iDTL_WriteValid(iDTL_WriteValid),
        .oDTL_WriteAccept(oDTL_WriteAccept),
        .iDTL_WriteData(iDTL_WriteData),
        .iDTL_WriteEnable(iDTL_WriteEnable),
        .iDTL_WriteLast(iDTL_WriteLast),
        .oDTL_ReadValid(oDTL_ReadValid),
        .iDTL_ReadAccept(iDTL_ReadAccept),
        .oDTL_ReadLast(oDTL_ReadLast),
        .oDTL_ReadData(oDTL_ReadData),
        .oIM_WriteEnable(oIM_WriteEnable),
        .oIM_WriteAddress(oIM_WriteAddress),
        .oIM_WriteData(oIM_WriteData),
        .oIM_WriteData_IMM(oIM_WriteData_IMM),
        .oBusy(oBusy),
        .oLoadDone(oLoadDone),
        .oError(oError)
    );

    typedef struct {
        logic [8:0]  en;
        logic [7:0]  addr;
        logic [11:0] d;
        logic [32:0] dImm;
        bit          imm;
    } wr_t;

    wr_t         expQ[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    int          expDone = 0;
    int          doneSeen = 0;
    int          strobeCnt = 0;
    bit          expErr = 0;
    logic [31:0] bd[16];
    logic [3:0]  be[16];
    logic [7:0]  lastAddr;
    logic [11:0] lastData;
    logic [32:0] lastImm;
    logic [8:0]  lastEn;

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Compare process: every strobe must match the head of the model queue.
    always @(negedge iClk) begin
        if (oLoadDone) doneSeen++;
        if (oDTL_ReadValid) check("rdData", oDTL_ReadData, 0);
        if (oIM_WriteEnable != 0) begin
            strobeCnt++;
            lastAddr = oIM_WriteAddress;
            lastData = oIM_WriteData;
            lastImm = oIM_WriteData_IMM;
            lastEn = oIM_WriteEnable;
            if (expQ.size() == 0) begin
                check("spuriousStrobe", oIM_WriteEnable, 0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("imEn", oIM_WriteEnable, e.en);
                check("imAddr", oIM_WriteAddress, e.addr);
                if (e.imm) check("imDataImm", oIM_WriteData_IMM, e.dImm);
                else check("imData", oIM_WriteData, e.d);
            end
        end
    end

    task automatic modelBurst(input int sel, input int word,
                              input int nBeats, input int lastAt,
                              input bit countDone);
        int endIdx;
        int a;
        bit valid;
        bit imm;
        wr_t e;
        endIdx = (lastAt < nBeats - 1) ? lastAt : nBeats - 1;
        a = word;
        valid = sel < 9;
        imm = sel < 3;
        if (!valid) expErr = 1;
        for (int i = 0; i <= endIdx; i++) begin
            if (imm && (i % 2 == 0)) begin
                if (i == endIdx) expErr = 1;
            end else begin
                e.en = 9'(1) << sel;
                e.addr = a[7:0];
                e.imm = imm;
                e.d = bd[i][11:0];
                e.dImm = '0;
                if (imm) begin
                    e.dImm = {bd[i][0], bd[i-1]};
                    if (valid && (be[i-1] | be[i]) != 0) expQ.push_back(e);
                end else begin
                    if (valid && be[i] != 0) expQ.push_back(e);
                end
                a = (a + 1) % 256;
            end
        end
        if (countDone) expDone++;
    endtask

    task automatic sendCmd(input bit rw, input logic [31:0] addr,
                           input logic [4:0] bs);
        int n;
        @(negedge iClk);
        iDTL_CommandValid = 1'b1;
        iDTL_CommandReadWrite = rw;
        iDTL_Address = addr;
        iDTL_BlockSize = bs;
        n = 0;
        while (!oDTL_CommandAccept && n < 50) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 50) check("cmdTimeout", 1, 0);
        @(posedge iClk);
        #1 iDTL_CommandValid = 1'b0;
    endtask

    task automatic driveBeats(input int n, input int lastAt, input bit gap);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) repeat (2) @(negedge iClk);
            @(negedge iClk);
            iDTL_WriteValid = 1'b1;
            iDTL_WriteData = bd[i];
            iDTL_WriteEnable = be[i];
            iDTL_WriteLast = (i == lastAt);
            w = 0;
            while (!oDTL_WriteAccept && w < 50) begin
                @(negedge iClk);
                w++;
            end
            if (w >= 50) check("beatTimeout", 1, 0);
            @(posedge iClk);
            #1;
            iDTL_WriteValid = 1'b0;
            iDTL_WriteLast = 1'b0;
        end
    endtask

    task automatic writeBurst(input int sel, input int word, input int bs,
                              input int lastAt, input bit gap);
        int n;
        n = ((lastAt < bs) ? lastAt : bs) + 1;
        modelBurst(sel, word, bs + 1, lastAt, 1);
        sendCmd(1'b0, (32'(sel) << 16) | (32'(word) << 2), 5'(bs));
        driveBeats(n, lastAt, gap);
    endtask

    task automatic endTest(input string name);
        repeat (4) @(negedge iClk);
        check({name, ".drained"}, expQ.size(), 0);
        check({name, ".loadDone"}, doneSeen, expDone);
        check({name, ".error"}, oError, expErr);
        check({name, ".busy"}, oBusy, 0);
    endtask

    task automatic fillEn();
        for (int i = 0; i < 16; i++) begin
            be[i] = 4'hF;
            bd[i] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iReset = 1'b1;
        iDTL_CommandValid = 1'b0;
        iDTL_CommandReadWrite = 1'b0;
        iDTL_Address = '0;
        iDTL_BlockSize = '0;
        iDTL_WriteValid = 1'b0;
        iDTL_WriteData = '0;
        iDTL_WriteEnable = '0;
        iDTL_WriteLast = 1'b0;
        iDTL_ReadAccept = 1'b0;
        fillEn();
        repeat (3) @(negedge iClk);
        check("rst.imEn", oIM_WriteEnable, 0);
        check("rst.cmdAcc", oDTL_CommandAccept, 0);
        check("rst.wrAcc", oDTL_WriteAccept, 0);
        check("rst.rdValid", oDTL_ReadValid, 0);
        check("rst.busy", oBusy, 0);
        check("rst.done", oLoadDone, 0);
        check("rst.error", oError, 0);
        iReset = 1'b0;

        // ID burst of four words
        fillEn();
        for (int i = 0; i < 4; i++) bd[i] = 32'hA + 32'(i);
        writeBurst(4, 'h10, 3, 99, 0);
        endTest("t1");
        check("t1.lastAddr", lastAddr, 8'h13);
        check("t1.lastData", lastData, 12'h00D);
        check("t1.strobes", strobeCnt, 4);

        // one packed immediate
        fillEn();
        bd[0] = 32'hDEADBEEF;
        bd[1] = 32'h1;
        writeBurst(1, 'h30, 1, 99, 0);
        endTest("t2");
        check("t2.imm", lastImm, 33'h1DEADBEEF);
        check("t2.en", lastEn, 9'h002);
        check("t2.error", oError, 0);

        // address wrap with valid gaps
        fillEn();
        bd[0] = 32'h11111111;
        bd[1] = 32'h0;
        bd[2] = 32'h22222222;
        bd[3] = 32'h1;
        writeBurst(0, 'hFF, 3, 99, 1);
        endTest("t3");
        check("t3.wrapAddr", lastAddr, 8'h00);
        check("t3.imm", lastImm, 33'h122222222);

        // early WriteLast on an IMM low beat, then an ID write
        fillEn();
        bd[0] = 32'hCAFE0001;
        bd[1] = 32'h0;
        bd[2] = 32'h12345678;
        writeBurst(2, 'h08, 7, 2, 0);
        endTest("t4");
        check("t4.errorSet", oError, 1);
        check("t4.addr", lastAddr, 8'h08);
        fillEn();
        bd[0] = 32'h00000ABC;
        writeBurst(3, 'h50, 0, 99, 0);
        endTest("t4b");
        check("t4b.data", lastData, 12'hABC);

        // read with stalled accept
        sendCmd(1'b1, 32'h0004_0000, 5'd2);
        for (int k = 0; k < 3; k++) begin
            repeat (2) begin
                @(negedge iClk);
                check("rdHold", oDTL_ReadValid, 1);
            end
            @(negedge iClk);
            iDTL_ReadAccept = 1'b1;
            check("rdLast", oDTL_ReadLast, 64'(k == 2));
            @(posedge iClk);
            #1 iDTL_ReadAccept = 1'b0;
        end
        @(negedge iClk);
        check("rdEnd", oDTL_ReadValid, 0);
        endTest("t5");

        // reset in the middle of a burst
        fillEn();
        bd[0] = 32'h1;
        bd[1] = 32'h2;
        modelBurst(5, 'h20, 4, 1, 0);
        sendCmd(1'b0, (32'd5 << 16) | (32'h20 << 2), 5'd3);
        driveBeats(2, 99, 0);
        @(negedge iClk);
        iReset = 1'b1;
        @(negedge iClk);
        iReset = 1'b0;
        expErr = 0;
        check("t6.imEn", oIM_WriteEnable, 0);
        check("t6.busy", oBusy, 0);
        check("t6.error", oError, 0);
        check("t6.wrAcc", oDTL_WriteAccept, 0);
        check("t6.cmdAcc", oDTL_CommandAccept, 0);
        check("t6.done", oLoadDone, 0);
        fillEn();
        bd[0] = 32'h777;
        bd[1] = 32'h888;
        be[1] = 4'h0;
        writeBurst(6, 'h40, 1, 99, 0);
        endTest("t6b");
        check("t6b.addr", lastAddr, 8'h40);
        check("t6b.data", lastData, 12'h777);

        // out-of-range select
        fillEn();
        writeBurst(12, 'h00, 1, 99, 0);
        endTest("t7");
        check("t7.error", oError, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
